cpu_core_mc: RTL and testbench
==============================

# cpu_core_mc

Parametrised multi-cycle successor to the team's 8-bit single-cycle CPU. It fetches 32-bit instructions over a request/ready handshake, executes them through a four-state FSM (FETCH, DECODE, EXECUTE, WRITEBACK), and adds conditional branches, jumps and an illegal-opcode halt. The block sits between instruction memory and the top-level testbench or SoC wrapper, and contains its own register file, ALU, negator path and program counter.

## Interface
- `DATA_WIDTH`, 8: register and ALU width; must be ≥ 8.
- `REG_COUNT`, 8: number of registers; power of two, 2..8 (register fields are 3 bits; unused upper index bits are ignored).
- `PC_WIDTH`, 32: program counter width.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high; clears all state immediately.
- `imem_req` output, 1 bit: fetch request; `pc` is valid while it is high.
- `imem_ready` input, 1 bit: memory has `instruction` valid.
- `instruction` input, 32 bits: fetched word.
- `pc` output, PC_WIDTH bits: current instruction address, byte-addressed, word-aligned.
- `halted` output, 1 bit: core stopped on an illegal opcode.
- `wb_valid` output, 1 bit: a register write commits this cycle.
- `wb_addr` output, 3 bits: destination of the commit.
- `wb_data` output, DATA_WIDTH bits: value written.

## Operation
- Field layout:
  - opcode = [31:24]
  - rd = [18:16]
  - rs1 = [10:8]
  - rs2 = [2:0]
  - imm = [7:0]
- Immediates are sign-extended to DATA_WIDTH (loadi) or PC_WIDTH (offsets).
- Opcodes:
  - 0x00 loadi: rd ← imm.
  - 0x01 mov: rd ← rs2.
  - 0x02 add: rd ← rs1 + rs2.
  - 0x03 sub: rd ← rs1 + (~rs2 + 1).
  - 0x04 and: rd ← rs1 & rs2.
  - 0x05 or: rd ← rs1 | rs2.
  - 0x06 j: pc ← pc + 4 + (imm << 2); no register write.
  - 0x07 beq: branch if rs1 == rs2.
  - 0x08 bne: branch if rs1 != rs2.
  - Any other opcode is illegal.
- Arithmetic wraps modulo 2^DATA_WIDTH; there are no flags other than the internal zero result used by beq/bne (computed as the zero flag of rs1 − rs2).
- FSM:
  - FETCH: `imem_req`=1. Stay in FETCH while `imem_ready`=0. On an edge with `imem_ready`=1, latch `instruction` into the instruction register and go to DECODE.
  - DECODE: read rs1 and rs2 into operand latches A and B. Check the opcode; an illegal opcode goes to HALT, otherwise go to EXECUTE.
  - EXECUTE: latch the ALU result and the branch-taken decision. Go to WRITEBACK.
  - WRITEBACK: for ALU and load ops, write rd and pulse `wb_valid`. Update `pc`: the branch target if taken, else pc + 4. Go to FETCH.
  - HALT: `halted`=1 and `imem_req`=0. HALT is terminal until reset.
- Any register, including r0, is writable. Reads in DECODE observe all prior WRITEBACK commits, so no hazards are possible.
- Branch target arithmetic wraps modulo 2^PC_WIDTH.

## Timing
- Reset values:
  - state = FETCH
  - `pc` = 0
  - all registers = 0
  - `imem_req` = 0
  - `halted` = 0
  - `wb_valid` = 0
  - `wb_addr` = 0
  - `wb_data` = 0
- Assertion of `reset` mid-instruction aborts it; no partial write commits.
- `imem_req` rises in the first cycle after `reset` deasserts.
- Latency is 4 cycles per instruction with zero fetch wait states; each `imem_ready`-low cycle adds one.
- `imem_req` is registered with the state. It is high throughout FETCH and low in every other state.
- `pc` is stable from FETCH entry until the WRITEBACK edge.
- `imem_ready` is ignored outside FETCH.
- `wb_valid`, `wb_addr` and `wb_data` are high/valid exactly during the WRITEBACK cycle of a writing instruction. The register file content changes on that cycle's closing edge.
- `halted` rises the cycle after DECODE of an illegal opcode. `pc` is left at the illegal instruction's address.

## Test plan
- Reset then fetch:
  - Hold `reset` 3 cycles, release.
  - Required: `imem_req`=1 with `pc`=0 next cycle, and all outputs at their reset values while `reset` is held.
- Arithmetic (DATA_WIDTH=8, ready always 1):
  - Program: loadi r1,0x05; loadi r2,0x03; sub r3,r1,r2; add r4,r1,r1; loadi r5,0xFF; add r6,r5,r1.
  - Required commits: r3=0x02, r4=0x0A, r6=0x04 (wrap); each commit exactly 4 cycles apart.
- Branches:
  - beq r1,r1,+2 at pc 0x10 → next `pc`=0x1C.
  - bne r1,r1 → `pc`=0x14.
  - j −1 (imm 0xFF) at 0x20 → `pc`=0x20 (self-loop).
- Handshake stall:
  - Hold `imem_ready`=0 for 5 cycles during fetch of add.
  - Required: `imem_req` stays 1, `pc` unchanged, commit delayed by exactly 5 cycles.
- Illegal opcode:
  - Fetch 0x09000000 at pc 0x08.
  - Required: `halted`=1 and `imem_req`=0 permanently, `pc`=0x08, no `wb_valid`; reset recovers.
- Width parameter:
  - With DATA_WIDTH=16, loadi r1,0x80 → `wb_data`=0xFF80.
  - Additionally, assert `reset` during EXECUTE: no commit occurs and `pc`=0.

Source files
------------

// File: rtl/cpu_core_mc.sv
// cpu_core_mc
// Multi-cycle core that fetches 32-bit instructions over a request/ready
// handshake and runs each one through FETCH, DECODE, EXECUTE and WRITEBACK.
// It holds its own register file, ALU and program counter, and stops in a
// terminal HALT state when it decodes an illegal opcode.
//
// Ports:
//   clk          single clock; all state changes on the rising edge
//   reset        asynchronous, active-high; clears all state
//   imem_req     fetch request; pc is valid while it is high
//   imem_ready   instruction memory has `instruction` valid (sampled in FETCH only)
//   instruction  fetched 32-bit word
//   pc           current byte address of the instruction, word aligned
//   halted       core stopped on an illegal opcode
//   wb_valid     a register write commits this cycle
//   wb_addr      destination register of the commit
//   wb_data      value being written
module cpu_core_mc #(
   parameter int DATA_WIDTH = 8,
   parameter int REG_COUNT  = 8,
   parameter int PC_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  imem_req,
   input  logic                  imem_ready,
   input  logic [31:0]           instruction,
   output logic [PC_WIDTH-1:0]   pc,
   output logic                  halted,
   output logic                  wb_valid,
   output logic [2:0]            wb_addr,
   output logic [DATA_WIDTH-1:0] wb_data
);

   localparam int IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      EXECUTE,
      WRITEBACK,
      HALT
   } state_t;

   state_t state;
   state_t state_next;

   logic [31:0]           ir;
   logic [DATA_WIDTH-1:0] op_a;
   logic [DATA_WIDTH-1:0] op_b;
   logic                  taken;
   logic [DATA_WIDTH-1:0] regs [REG_COUNT];

   logic [7:0]            opcode;
   logic [IDX_W-1:0]      rd_idx;
   logic [IDX_W-1:0]      rs1_idx;
   logic [IDX_W-1:0]      rs2_idx;
   logic                  is_write;
   logic                  is_legal;
   logic                  fetch_done;

   logic [DATA_WIDTH-1:0] imm_data;
   logic [DATA_WIDTH-1:0] diff;
   logic [DATA_WIDTH-1:0] alu_result;
   logic                  branch_cond;
   logic [PC_WIDTH-1:0]   pc_plus4;
   logic [PC_WIDTH-1:0]   target;

   // Instruction bits outside the defined fields carry no meaning; the upper
   // register-index bits are also ignored when REG_COUNT is below eight.
   logic unused_bits;
   assign unused_bits = ^{ir[23:19], ir[15:11], ir[10:8]};

   assign opcode     = ir[31:24];
   assign rd_idx     = ir[16 +: IDX_W];
   assign rs1_idx    = ir[8 +: IDX_W];
   assign rs2_idx    = ir[0 +: IDX_W];
   assign is_write   = (opcode <= 8'h05);
   assign is_legal   = (opcode <= 8'h08);
   assign fetch_done = (state == FETCH) && imem_req && imem_ready;

   // ALU and branch resolution. Subtraction goes through the negator path,
   // and its zero result is the only condition beq/bne look at.
   always_comb begin
      imm_data    = DATA_WIDTH'($signed(ir[7:0]));
      diff        = op_a + (~op_b + DATA_WIDTH'(1));
      alu_result  = '0;
      branch_cond = 1'b0;
      case (opcode)
         8'h00:   alu_result = imm_data;
         8'h01:   alu_result = op_b;
         8'h02:   alu_result = op_a + op_b;
         8'h03:   alu_result = diff;
         8'h04:   alu_result = op_a & op_b;
         8'h05:   alu_result = op_a | op_b;
         8'h06:   branch_cond = 1'b1;
         8'h07:   branch_cond = (diff == '0);
         8'h08:   branch_cond = (diff != '0);
         default: alu_result = '0;
      endcase
      pc_plus4 = pc + PC_WIDTH'(4);
      target   = pc_plus4 + (PC_WIDTH'($signed(ir[7:0])) << 2);
   end

   // Next-state logic. The fetch handshake only counts once imem_req is up,
   // so a ready seen in the bubble cycle right after reset is not taken.
   always_comb begin
      state_next = state;
      case (state)
         FETCH:     if (fetch_done) state_next = DECODE;
         DECODE:    state_next = is_legal ? EXECUTE : HALT;
         EXECUTE:   state_next = WRITEBACK;
         WRITEBACK: state_next = FETCH;
         HALT:      state_next = HALT;
         default:   state_next = FETCH;
      endcase
   end

   // State, registered status outputs and datapath latches. imem_req and
   // halted follow the state they will be in, so they are registered
   // alongside it. The commit outputs are loaded on the EXECUTE edge, which
   // makes them valid for exactly the WRITEBACK cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= FETCH;
         imem_req <= 1'b0;
         halted   <= 1'b0;
         wb_valid <= 1'b0;
         wb_addr  <= '0;
         wb_data  <= '0;
         taken    <= 1'b0;
         pc       <= '0;
         ir       <= '0;
         op_a     <= '0;
         op_b     <= '0;
      end else begin
         state    <= state_next;
         imem_req <= (state_next == FETCH);
         halted   <= (state_next == HALT);
         wb_valid <= 1'b0;
         wb_addr  <= '0;
         wb_data  <= '0;
         if (fetch_done) begin
            ir <= instruction;
         end
         if (state == DECODE) begin
            op_a <= regs[rs1_idx];
            op_b <= regs[rs2_idx];
         end
         if (state == EXECUTE) begin
            taken <= branch_cond;
            if (is_write) begin
               wb_valid <= 1'b1;
               wb_addr  <= ir[18:16];
               wb_data  <= alu_result;
            end
         end
         if (state == WRITEBACK) begin
            pc <= taken ? target : pc_plus4;
         end
      end
   end

   // Register file. It is written from the commit outputs on the closing
   // edge of WRITEBACK, so a following DECODE always sees the new value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_valid) begin
         regs[rd_idx] <= wb_data;
      end
   end

endmodule

// File: tb/tb_cpu_core_mc.sv
// tb_cpu_core_mc
// Drives an 8-bit and a 16-bit cpu_core_mc in lockstep from the same
// instruction stream and compares their fetch, commit and pc behaviour
// against a table of hand-computed vectors, hand-written corner-case
// sequences and an instruction-level reference model under random programs.
module tb_cpu_core_mc;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_ready;
   logic [31:0] instruction;

   logic        req8, halted8, wbv8;
   logic [31:0] pc8;
   logic [2:0]  wba8;
   logic [7:0]  wbd8;
   logic        req16, halted16, wbv16;
   logic [31:0] pc16;
   logic [2:0]  wba16;
   logic [15:0] wbd16;

   always #5 clk = ~clk;

   cpu_core_mc #(.DATA_WIDTH(8), .REG_COUNT(8), .PC_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .imem_req(req8), .imem_ready(imem_ready),
      .instruction(instruction), .pc(pc8), .halted(halted8),
      .wb_valid(wbv8), .wb_addr(wba8), .wb_data(wbd8)
   );

   cpu_core_mc #(.DATA_WIDTH(16), .REG_COUNT(8), .PC_WIDTH(32)) dut16 (
      .clk(clk), .reset(reset), .imem_req(req16), .imem_ready(imem_ready),
      .instruction(instruction), .pc(pc16), .halted(halted16),
      .wb_valid(wbv16), .wb_addr(wba16), .wb_data(wbd16)
   );

   int nTests = 0;
   int nFail  = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // What one instruction looked like from the outside
   typedef struct {
      logic [31:0] pcFetch;
      logic [31:0] pcFetch16;
      bit          stallOk;
      int          wbRel;
      logic [2:0]  wbA;
      logic [7:0]  wbD8;
      logic [15:0] wbD16;
      int          wbAbs;
      int          fetchRel;
      logic [31:0] pcAfter;
      logic [31:0] pcAfter16;
   } obs_t;

   typedef struct {
      logic [31:0] instr;
      int          stall;
      bit          expWb;
      logic [2:0]  expAddr;
      logic [7:0]  expD8;
      logic [15:0] expD16;
      logic [31:0] expPc;
      int          expGap;
   } vec_t;

   // Instruction-level reference model: index 0 is the 8-bit core, 1 the 16-bit
   longint unsigned mreg [2][8];
   logic [31:0]     mpc  [2];

   function automatic logic [31:0] enc(input logic [7:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [7:0] lo);
      return {op, 5'b0, rd, 5'b0, rs1, lo};
   endfunction

   function automatic void modelReset();
      for (int k = 0; k < 2; k++) begin
         mpc[k] = 32'h0;
         for (int i = 0; i < 8; i++) mreg[k][i] = 0;
      end
   endfunction

   function automatic void modelExec(input int k, input logic [31:0] instr, output bit w,
                                     output logic [2:0] rd, output longint unsigned v);
      longint unsigned mask;
      longint unsigned a;
      longint unsigned b;
      int              s;
      bit              tk;
      mask = (k == 0) ? 64'hFF : 64'hFFFF;
      a    = mreg[k][instr[10:8]];
      b    = mreg[k][instr[2:0]];
      s    = int'($signed(instr[7:0]));
      tk   = 1'b0;
      w    = 1'b1;
      rd   = instr[18:16];
      v    = 0;
      case (instr[31:24])
         8'h00:   v = longint'(s) & mask;
         8'h01:   v = b;
         8'h02:   v = (a + b) & mask;
         8'h03:   v = (a - b) & mask;
         8'h04:   v = a & b;
         8'h05:   v = a | b;
         8'h06:   begin w = 1'b0; tk = 1'b1; end
         8'h07:   begin w = 1'b0; tk = (a == b); end
         default: begin w = 1'b0; tk = (a != b); end
      endcase
      if (w) mreg[k][rd] = v;
      mpc[k] = tk ? mpc[k] + 32'(4 + 4 * s) : mpc[k] + 32'd4;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Waits (bounded) for a fetch request, optionally stalls it, hands over the
   // instruction and then watches until the next request or a halt.
   task automatic applyStimulus(input logic [31:0] instr, input int stall, output obs_t o);
      int n;
      n = 0;
      imem_ready = 1'b0;
      while (req8 !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("fetch_request", {63'b0, req8}, 64'd1);
      o.pcFetch   = pc8;
      o.pcFetch16 = pc16;
      o.stallOk   = 1'b1;
      o.wbRel     = -1;
      o.wbA       = '0;
      o.wbD8      = '0;
      o.wbD16     = '0;
      o.wbAbs     = -1;
      o.fetchRel  = -1;
      for (int i = 0; i < stall; i++) begin
         instruction = $urandom;
         @(negedge clk);
         if (req8 !== 1'b1 || pc8 !== o.pcFetch) o.stallOk = 1'b0;
      end
      instruction = instr;
      imem_ready  = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         instruction = $urandom;
         imem_ready  = 1'($urandom_range(0, 1));
         if (wbv8 === 1'b1 && o.wbRel < 0) begin
            o.wbRel = c;
            o.wbA   = wba8;
            o.wbD8  = wbd8;
            o.wbD16 = wbd16;
            o.wbAbs = cyc;
         end
         if (req8 === 1'b1 || halted8 === 1'b1) begin
            o.fetchRel = c;
            break;
         end
      end
      imem_ready  = 1'b0;
      o.pcAfter   = pc8;
      o.pcAfter16 = pc16;
   endtask

   vec_t        vecs[$];
   obs_t        ob;
   logic [31:0] expFetch;
   int          lastWb;
   bit          stickyOk;
   bit          mw;
   logic [2:0]  mrd;
   longint unsigned mv8, mv16;
   logic [31:0] rinstr;
   int          rsel;
   int          rstall;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, actual running, required finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      // Program for the table: beq/bne use r2,r2 because an offset of +2
      // places 2 in the rs2 field as well.
      vecs.push_back('{enc(8'h00, 3'd1, 3'd0, 8'h05), 0, 1'b1, 3'd1, 8'h05, 16'h0005, 32'h04, 0});
      vecs.push_back('{enc(8'h00, 3'd2, 3'd0, 8'h03), 0, 1'b1, 3'd2, 8'h03, 16'h0003, 32'h08, 4});
      vecs.push_back('{enc(8'h03, 3'd3, 3'd1, 8'h02), 0, 1'b1, 3'd3, 8'h02, 16'h0002, 32'h0C, 4});
      vecs.push_back('{enc(8'h02, 3'd4, 3'd1, 8'h01), 0, 1'b1, 3'd4, 8'h0A, 16'h000A, 32'h10, 4});
      vecs.push_back('{enc(8'h07, 3'd0, 3'd2, 8'h02), 0, 1'b0, 3'd0, 8'h00, 16'h0000, 32'h1C, 0});
      vecs.push_back('{enc(8'h00, 3'd5, 3'd0, 8'hFF), 0, 1'b1, 3'd5, 8'hFF, 16'hFFFF, 32'h20, 0});
      vecs.push_back('{enc(8'h06, 3'd0, 3'd0, 8'hFF), 0, 1'b0, 3'd0, 8'h00, 16'h0000, 32'h20, 0});
      vecs.push_back('{enc(8'h08, 3'd0, 3'd2, 8'h02), 0, 1'b0, 3'd0, 8'h00, 16'h0000, 32'h24, 0});
      vecs.push_back('{enc(8'h00, 3'd7, 3'd0, 8'h80), 0, 1'b1, 3'd7, 8'h80, 16'hFF80, 32'h28, 0});
      vecs.push_back('{enc(8'h02, 3'd6, 3'd5, 8'h01), 5, 1'b1, 3'd6, 8'h04, 16'h0004, 32'h2C, 9});
      vecs.push_back('{enc(8'h05, 3'd3, 3'd4, 8'h02), 0, 1'b1, 3'd3, 8'h0B, 16'h000B, 32'h30, 4});
      vecs.push_back('{enc(8'h01, 3'd0, 3'd0, 8'h06), 0, 1'b1, 3'd0, 8'h04, 16'h0004, 32'h34, 4});
      vecs.push_back('{enc(8'h04, 3'd1, 3'd4, 8'h03), 0, 1'b1, 3'd1, 8'h0A, 16'h000A, 32'h38, 4});

      // Reset held three cycles, then the first request
      reset       = 1'b1;
      imem_ready  = 1'b0;
      instruction = 32'h0;
      repeat (3) begin
         @(negedge clk);
         checkOutput("reset_outputs8", {18'b0, req8, halted8, wbv8, wba8, wbd8, pc8}, 64'd0);
         checkOutput("reset_outputs16", {10'b0, req16, halted16, wbv16, wba16, wbd16, pc16}, 64'd0);
      end
      reset = 1'b0;
      #1;
      checkOutput("req_low_at_release", {63'b0, req8}, 64'd0);
      @(negedge clk);
      checkOutput("req_after_reset", {63'b0, req8}, 64'd1);
      checkOutput("pc_after_reset", {32'b0, pc8}, 64'd0);

      // Table-driven program
      expFetch = 32'h0;
      lastWb   = -1;
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].instr, vecs[i].stall, ob);
         checkOutput($sformatf("vec%0d_fetch_pc", i), {32'b0, ob.pcFetch}, {32'b0, expFetch});
         if (vecs[i].stall > 0)
            checkOutput($sformatf("vec%0d_stall_hold", i), {63'b0, ob.stallOk}, 64'd1);
         checkOutput($sformatf("vec%0d_wb_cycle", i), 64'(ob.wbRel), vecs[i].expWb ? 64'd3 : 64'(-1));
         if (vecs[i].expWb) begin
            checkOutput($sformatf("vec%0d_wb_addr", i), {61'b0, ob.wbA}, {61'b0, vecs[i].expAddr});
            checkOutput($sformatf("vec%0d_wb_data8", i), {56'b0, ob.wbD8}, {56'b0, vecs[i].expD8});
            checkOutput($sformatf("vec%0d_wb_data16", i), {48'b0, ob.wbD16}, {48'b0, vecs[i].expD16});
            if (vecs[i].expGap > 0)
               checkOutput($sformatf("vec%0d_commit_gap", i), 64'(ob.wbAbs - lastWb), 64'(vecs[i].expGap));
            lastWb = ob.wbAbs;
         end
         checkOutput($sformatf("vec%0d_latency", i), 64'(ob.fetchRel), 64'd4);
         checkOutput($sformatf("vec%0d_next_pc", i), {32'b0, ob.pcAfter}, {32'b0, vecs[i].expPc});
         expFetch = vecs[i].expPc;
      end

      // Illegal opcode at pc 0x08 halts for good
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      applyStimulus(enc(8'h00, 3'd1, 3'd0, 8'h01), 0, ob);
      applyStimulus(enc(8'h00, 3'd2, 3'd0, 8'h02), 0, ob);
      applyStimulus(32'h09000000, 0, ob);
      checkOutput("illegal_fetch_pc", {32'b0, ob.pcFetch}, 64'h08);
      checkOutput("illegal_halted", {62'b0, halted8, req8}, 64'b10);
      checkOutput("illegal_no_commit", 64'(ob.wbRel), 64'(-1));
      checkOutput("illegal_pc", {32'b0, ob.pcAfter}, 64'h08);
      stickyOk = 1'b1;
      repeat (10) begin
         imem_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (halted8 !== 1'b1 || req8 !== 1'b0 || wbv8 !== 1'b0 || pc8 !== 32'h08) stickyOk = 1'b0;
      end
      imem_ready = 1'b0;
      checkOutput("halt_sticky", {63'b0, stickyOk}, 64'd1);
      reset = 1'b1;
      #1;
      checkOutput("halt_cleared_by_reset", {63'b0, halted8}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("recover_fetch", {31'b0, req8, pc8}, {31'b0, 1'b1, 32'h0});

      // Reset during EXECUTE aborts the instruction without a commit
      instruction = enc(8'h00, 3'd3, 3'd0, 8'h11);
      imem_ready  = 1'b1;
      @(negedge clk);
      imem_ready  = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("abort_outputs8", {29'b0, wbv8, req8, halted8, pc8}, 64'd0);
      checkOutput("abort_outputs16", {29'b0, wbv16, req16, halted16, pc16}, 64'd0);
      stickyOk = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (wbv8 !== 1'b0 || wbv16 !== 1'b0) stickyOk = 1'b0;
      end
      reset = 1'b0;
      @(negedge clk);
      if (wbv8 !== 1'b0) stickyOk = 1'b0;
      checkOutput("abort_no_commit", {63'b0, stickyOk}, 64'd1);
      checkOutput("abort_refetch_pc0", {31'b0, req8, pc8}, {31'b0, 1'b1, 32'h0});

      // Random programs against the reference model
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      modelReset();
      for (int t = 0; t < 60; t++) begin
         rsel = $urandom_range(0, 11);
         if (rsel > 8) rsel = 0;
         rinstr = enc(8'(rsel), 3'($urandom), 3'($urandom), 8'($urandom));
         rstall = $urandom_range(0, 2);
         applyStimulus(rinstr, rstall, ob);
         checkOutput($sformatf("rnd%0d_fetch_pc", t), {ob.pcFetch16, ob.pcFetch}, {mpc[1], mpc[0]});
         modelExec(0, rinstr, mw, mrd, mv8);
         modelExec(1, rinstr, mw, mrd, mv16);
         checkOutput($sformatf("rnd%0d_wb_cycle", t), 64'(ob.wbRel), mw ? 64'd3 : 64'(-1));
         if (mw)
            checkOutput($sformatf("rnd%0d_wb", t), {ob.wbA, ob.wbD8, ob.wbD16},
                        {mrd, mv8[7:0], mv16[15:0]});
         checkOutput($sformatf("rnd%0d_next_pc", t), {ob.pcAfter16, ob.pcAfter}, {mpc[1], mpc[0]});
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
